stream_capture: RTL and testbench
=================================

# stream_capture

Avalon-ST sink that terminates the convolution output feature stream (`f2_st_*`) and buffers accepted samples in an internal FIFO. Host software drains the buffer and checks packet framing through an Avalon-MM slave. The block applies backpressure through `st_ready` and never drops a framed beat. It is the downstream counterpart of the feature/kernel stream sources that drive the convolution engine.

## Interface
Parameters:
- `WIDTH`, 16, sample width (bfloat16 payload)
- `DEPTH`, 256, FIFO entries; power of 2, minimum 4
- `LW`, `$clog2(DEPTH)+1`, fill-level width (derived; not overridden)

Ports:
- `clock`  in  1  single clock; all logic on rising edge
- `clock_sreset`  in  1  reset, asynchronous, active-high
- `s_address`  in  4  register word address
- `s_writedata`  in  32  write data
- `s_readdata`  out  32  read data; registered
- `s_read`  in  1  read strobe
- `s_write`  in  1  write strobe
- `s_waitrequest`  out  1  slave stall
- `st_ready`  out  1  sink ready; ready latency 0
- `st_valid`  in  1  beat valid
- `st_sop`  in  1  start of packet
- `st_eop`  in  1  end of packet
- `st_data`  in  WIDTH  sample

## Operation
- Registers (word addresses):
  - 0 CONTROL: bit0 `enable` (R/W, reset 0); bit1 `clear` (write-1 pulse, reads 0)
  - 1 LENGTH: [15:0] expected samples per packet (reset 0); 0 disables the length check
  - 2 STATUS: bit0 empty; bit1 full; bit2 pkt_done; bit3 sop_err; bit4 len_err; [31:16] fill level. Bits 2–4 are sticky and cleared by writing 1 to the same bit.
  - 3 DATA: each read pops one entry and returns {14'b0, eop, sop, data}; bit16 is sop and bit17 is eop. A read while empty returns 0 and does not pop.
  - 4 PKTCOUNT: completed packets (32-bit, wraps)
  - Other addresses read 0; writes to them are ignored.
- Readiness: `st_ready` = enable & ~full. A beat is accepted when st_valid & st_ready.
- Framing FSM, states IDLE and INPKT:
  - IDLE + beat with sop: store the beat, set sample count to 1, go to INPKT.
  - IDLE + beat without sop: discard the beat (not stored), set sop_err, stay in IDLE.
  - INPKT + beat without sop: store the beat, increment the count.
  - INPKT + beat with sop: set sop_err, store the beat, restart the count at 1; the previous packet is abandoned.
  - Any stored beat with eop: go to IDLE, increment PKTCOUNT, set pkt_done, run the length check (see Configuration).
  - sop and eop on the same beat: a one-sample packet, count 1.
- `clear`: empties the FIFO, returns the FSM to IDLE, zeroes the sample count, and clears STATUS bits 2–4. PKTCOUNT, LENGTH and enable are kept. A beat in the same cycle as clear is dropped; clear wins.
- Simultaneous push and DATA pop: both happen and the fill level is unchanged. A pop when full and a push in the same cycle are both legal.
- Sample count saturates at 16'hFFFF.

## Timing
- Reset values: `s_readdata` 0; `s_waitrequest` 0; `st_ready` 0; FIFO empty; FSM IDLE; all registers 0.
- Write: zero wait state. `s_waitrequest` stays low and the write takes effect at that edge. An enable write affects `st_ready` from the next cycle.
- Read, 1 wait state:
  - Cycle of first `s_read`: `s_waitrequest` = 1.
  - Next cycle: `s_waitrequest` = 0 and `s_readdata` is valid; the read completes and a DATA pop occurs at that edge.
  - Back-to-back reads each take 2 cycles.
- A beat accepted at edge N appears in STATUS fill level and in DATA from cycle N+1.
- `full` and `st_ready` update in the cycle after the push or pop that changes them.
- Reset asserted mid-packet or mid-read: all state returns to reset values immediately (asynchronous). Any pending read is abandoned.

## Configuration
- `STREAM_CAPTURE_LENCHECK_EN` defined: on each eop, if LENGTH ≠ 0 and count ≠ LENGTH, set len_err.
- `STREAM_CAPTURE_LENCHECK_EN` not defined:
  - No length comparator or sample counter is built.
  - LENGTH reads 0 and ignores writes.
  - len_err always reads 0.

## Test plan
- Reset, then enable, LENGTH=256. Send a 256-beat packet with 16'h3F80 at index 15 and 0 elsewhere -> PKTCOUNT=1, pkt_done=1, len_err=0, fill=256. The 16th DATA read returns 0x00003F80; the first read has bit16 set; the last has bit17 set.
- DEPTH=256, send 300 beats with no reads -> `st_ready` low at fill=256. Drain one DATA read -> exactly one more beat accepted; no beat lost; order preserved.
- Beat without sop while IDLE -> sop_err=1, fill=0. Sop mid-packet -> sop_err=1 and count restarts. A later 9-beat packet with LENGTH=9 -> len_err stays 0 after the sticky bits are cleared.
- LENGTH=9, send a 10-beat packet -> len_err=1 (macro defined); len_err=0 (macro undefined).
- Write clear in the same cycle as a valid beat with fill=5 -> fill=0, FSM IDLE, beat dropped, PKTCOUNT unchanged.
- Assert `clock_sreset` mid-packet with fill=40 and a read pending -> all outputs at reset values in the same cycle; `st_ready`=0 until enable is rewritten.

Source files
------------

// File: rtl/stream_capture.sv
// Avalon-ST capture sink with Avalon-MM drain/status port.
// Optional build macro: STREAM_CAPTURE_LENCHECK_EN (sample counter and packet length check).

// Circular buffer with level count, synchronous clear and same-cycle push/pop.
// Latency: a push is visible at head/level the cycle after its edge.
// Backpressure: push is ignored when full unless a pop frees a slot in the same cycle.
module stream_capture_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 256,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             clock_sreset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [LW-1:0]    level,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge clock_sreset) begin
    if (clock_sreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      level <= level + LW'(1);
      else if (!do_push && do_pop) level <= level - LW'(1);
    end
  end
endmodule

// Terminates a framed sample stream into a FIFO; host drains and checks framing over MM.
// Latency: accepted beat visible in STATUS/DATA next cycle; MM reads take one wait state.
// Backpressure: st_ready = enable & ~full; framed beats are never dropped once accepted.
module stream_capture #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             clock_sreset,
  input  logic [3:0]       s_address,
  input  logic [31:0]      s_writedata,
  output logic [31:0]      s_readdata,
  input  logic             s_read,
  input  logic             s_write,
  output logic             s_waitrequest,
  output logic             st_ready,
  input  logic             st_valid,
  input  logic             st_sop,
  input  logic             st_eop,
  input  logic [WIDTH-1:0] st_data
);
  typedef enum logic {IDLE, INPKT} state_t;

  state_t              state_q, state_d;
  logic                enable;
  logic                pkt_done;
  logic                sop_err;
  logic                len_err;
  logic [31:0]         pktcount;
  logic                rd_pend;
  logic                rd_pop_ok;
  logic [31:0]         rd_mux;
  logic                clr;
  logic                sts_wr;
  logic                accept;
  logic                store;
  logic                sop_err_set;
  logic                pkt_end;
  logic                len_set;
  logic [15:0]         length_rd;
  logic [WIDTH+1:0]    head;
  logic [LW-1:0]       level;
  logic                empty;
  logic                full;
  logic                rd_start;
  logic                rd_done;
  logic                unused;

  assign unused   = ^s_writedata;
  assign clr      = s_write && (s_address == 4'd0) && s_writedata[1];
  assign sts_wr   = s_write && (s_address == 4'd2);
  assign st_ready = enable & ~full;
  assign accept   = st_valid & st_ready & ~clr;
  assign pkt_end  = store & st_eop;
  assign rd_start = s_read & ~rd_pend;
  assign rd_done  = s_read & rd_pend;
  // Reset forces the stall low even while a master still holds s_read.
  assign s_waitrequest = rd_start & ~clock_sreset;

  stream_capture_fifo #(.WIDTH(WIDTH + 2), .DEPTH(DEPTH), .LW(LW)) u_fifo (
    .clock        (clock),
    .clock_sreset (clock_sreset),
    .clear        (clr),
    .push         (store),
    .push_data    ({st_eop, st_sop, st_data}),
    .pop          (rd_done & rd_pop_ok),
    .head         (head),
    .level        (level),
    .empty        (empty),
    .full         (full)
  );

  always_ff @(posedge clock or posedge clock_sreset) begin
    if (clock_sreset) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    store       = 1'b0;
    sop_err_set = 1'b0;
    if (clr) begin
      state_d = IDLE;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (st_sop) begin
            store   = 1'b1;
            state_d = st_eop ? IDLE : INPKT;
          end else begin
            sop_err_set = 1'b1;
          end
        end
        INPKT: begin
          store       = 1'b1;
          sop_err_set = st_sop;
          if (st_eop) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef STREAM_CAPTURE_LENCHECK_EN
  logic [15:0] length_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)        cnt_d = '0;
    else if (store) cnt_d = st_sop ? 16'd1 : ((cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1);
  end

  always_ff @(posedge clock or posedge clock_sreset) begin
    if (clock_sreset) begin
      length_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (s_write && s_address == 4'd1) length_q <= s_writedata[15:0];
    end
  end

  assign length_rd = length_q;
  assign len_set   = pkt_end && (length_q != 16'd0) && (cnt_d != length_q);
`else
  assign length_rd = 16'd0;
  assign len_set   = 1'b0;
`endif

  always_ff @(posedge clock or posedge clock_sreset) begin
    if (clock_sreset) begin
      enable   <= 1'b0;
      pkt_done <= 1'b0;
      sop_err  <= 1'b0;
      len_err  <= 1'b0;
      pktcount <= '0;
    end else begin
      if (s_write && s_address == 4'd0) enable <= s_writedata[0];
      if (pkt_end) pktcount <= pktcount + 32'd1;
      // A flag raised in the same cycle as its write-1-clear stays set.
      if (clr) begin
        pkt_done <= 1'b0;
        sop_err  <= 1'b0;
        len_err  <= 1'b0;
      end else begin
        if (pkt_end)                        pkt_done <= 1'b1;
        else if (sts_wr && s_writedata[2])  pkt_done <= 1'b0;
        if (sop_err_set)                    sop_err  <= 1'b1;
        else if (sts_wr && s_writedata[3])  sop_err  <= 1'b0;
        if (len_set)                        len_err  <= 1'b1;
        else if (sts_wr && s_writedata[4])  len_err  <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (s_address)
      4'd0: rd_mux = {31'd0, enable};
      4'd1: rd_mux = {16'd0, length_rd};
      4'd2: rd_mux = {16'(level), 11'd0, len_err, sop_err, pkt_done, full, empty};
      4'd3: rd_mux = empty ? 32'd0 : 32'(head);
      4'd4: rd_mux = pktcount;
      default: rd_mux = '0;
    endcase
  end

  // Read data is captured in the wait-state cycle; the pop happens when the read completes.
  always_ff @(posedge clock or posedge clock_sreset) begin
    if (clock_sreset) begin
      rd_pend    <= 1'b0;
      rd_pop_ok  <= 1'b0;
      s_readdata <= '0;
    end else begin
      rd_pend <= rd_start;
      if (rd_start) begin
        s_readdata <= rd_mux;
        rd_pop_ok  <= (s_address == 4'd3) && !empty;
      end else if (rd_done) begin
        rd_pop_ok  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stream_capture.sv
// Directed self-checking bench for stream_capture (DEPTH=256, WIDTH=16).
module tb_stream_capture;
  logic        clock;
  logic        clock_sreset;
  logic [3:0]  s_address;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic        s_read;
  logic        s_write;
  logic        s_waitrequest;
  logic        st_ready;
  logic        st_valid;
  logic        st_sop;
  logic        st_eop;
  logic [15:0] st_data;

  int checks = 0;
  int failures = 0;
  int accepted = 0;
  logic first_wait;

`ifdef STREAM_CAPTURE_LENCHECK_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif

  stream_capture dut (
    .clock         (clock),
    .clock_sreset  (clock_sreset),
    .s_address     (s_address),
    .s_writedata   (s_writedata),
    .s_readdata    (s_readdata),
    .s_read        (s_read),
    .s_write       (s_write),
    .s_waitrequest (s_waitrequest),
    .st_ready      (st_ready),
    .st_valid      (st_valid),
    .st_sop        (st_sop),
    .st_eop        (st_eop),
    .st_data       (st_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    s_address = a; s_writedata = d; s_write = 1'b1;
    @(posedge clock); #1;
    s_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    int n;
    s_address = a; s_read = 1'b1; n = 0;
    @(negedge clock);
    first_wait = s_waitrequest;
    while (s_waitrequest === 1'b1 && n < 8) begin
      @(negedge clock);
      n++;
    end
    d = s_readdata;
    @(posedge clock); #1;
    s_read = 1'b0;
    chk("rd_ack", 32'(n < 8), 32'd1);
  endtask

  task automatic rdchk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic send(input logic [15:0] d, input logic sop, input logic eop);
    int n;
    logic done;
    st_valid = 1'b1; st_data = d; st_sop = sop; st_eop = eop; n = 0; done = 1'b0;
    while (!done && n < 16) begin
      @(negedge clock);
      done = st_ready;
      @(posedge clock); #1;
      n++;
    end
    st_valid = 1'b0;
    chk("send_ready", 32'(done), 32'd1);
  endtask

  task automatic stream_cycles(input int n);
    logic r;
    st_valid = 1'b1;
    for (int c = 0; c < n; c++) begin
      st_data = 16'(accepted); st_sop = (accepted == 0); st_eop = 1'b0;
      @(negedge clock);
      r = st_ready;
      @(posedge clock); #1;
      if (r) accepted++;
    end
    st_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] exp5 [5];
    clock_sreset = 1'b1; s_address = '0; s_writedata = '0; s_read = 1'b0; s_write = 1'b0;
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0; st_data = '0;

    // Reset values
    @(negedge clock);
    chk("rst_readdata", s_readdata, 32'd0);
    chk("rst_wait", 32'(s_waitrequest), 32'd0);
    chk("rst_ready", 32'(st_ready), 32'd0);
    @(posedge clock); #1;
    clock_sreset = 1'b0;
    rdchk("rst_status", 4'd2, 32'h0000_0001);
    chk("rd_first_wait", 32'(first_wait), 32'd1);

    // 256-beat packet, LENGTH=256
    wr(4'd0, 32'd1);
    @(negedge clock);
    chk("en_ready", 32'(st_ready), 32'd1);
    @(posedge clock); #1;
    wr(4'd1, 32'd256);
    rdchk("length_rd", 4'd1, LEN_EN ? 32'd256 : 32'd0);
    for (int i = 0; i < 256; i++) send((i == 15) ? 16'h3F80 : 16'h0000, i == 0, i == 255);
    @(negedge clock);
    chk("full_ready", 32'(st_ready), 32'd0);
    @(posedge clock); #1;
    rdchk("p1_status", 4'd2, 32'h0100_0006);
    rdchk("p1_pktcount", 4'd4, 32'd1);
    for (int i = 0; i < 256; i++) begin
      rd(4'd3, d);
      chk("p1_data", d, ((i == 15) ? 32'h3F80 : 32'd0) | ((i == 0) ? 32'h1_0000 : 32'd0)
                        | ((i == 255) ? 32'h2_0000 : 32'd0));
    end
    rdchk("p1_empty", 4'd2, 32'h0000_0005);
    wr(4'd2, 32'h1C);
    rdchk("sticky_clr", 4'd2, 32'h0000_0001);
    rdchk("empty_data", 4'd3, 32'd0);

    // Backpressure: 300 attempts into 256 entries
    accepted = 0;
    stream_cycles(300);
    chk("bp_accepted", 32'(accepted), 32'd256);
    @(negedge clock);
    chk("bp_ready", 32'(st_ready), 32'd0);
    @(posedge clock); #1;
    rdchk("bp_status", 4'd2, 32'h0100_0002);
    rdchk("bp_first", 4'd3, 32'h0001_0000);
    stream_cycles(5);
    chk("bp_one_more", 32'(accepted), 32'd257);
    for (int i = 1; i <= 256; i++) rdchk("bp_order", 4'd3, 32'(i));
    rdchk("bp_drained", 4'd2, 32'h0000_0001);
    wr(4'd0, 32'd3);
    rdchk("bp_pktcount", 4'd4, 32'd1);

    // Framing errors
    send(16'h0001, 1'b0, 1'b0);
    rdchk("nosop_status", 4'd2, 32'h0000_0009);
    wr(4'd2, 32'h08);
    wr(4'd1, 32'd3);
    send(16'h000A, 1'b1, 1'b0);
    send(16'h000B, 1'b0, 1'b0);
    send(16'h000C, 1'b1, 1'b0);
    send(16'h000D, 1'b0, 1'b0);
    send(16'h000E, 1'b0, 1'b1);
    rdchk("restart_status", 4'd2, 32'h0005_000C);
    rdchk("restart_pktcount", 4'd4, 32'd2);
    exp5 = '{32'h1_000A, 32'h0_000B, 32'h1_000C, 32'h0_000D, 32'h2_000E};
    for (int i = 0; i < 5; i++) rdchk("restart_data", 4'd3, exp5[i]);
    wr(4'd2, 32'h1C);
    wr(4'd1, 32'd9);
    for (int i = 0; i < 9; i++) send(16'(16'h100 + i), i == 0, i == 8);
    rdchk("len9_status", 4'd2, 32'h0009_0004);
    rdchk("len9_pktcount", 4'd4, 32'd3);
    wr(4'd0, 32'd3);
    rdchk("clr_status", 4'd2, 32'h0000_0001);

    // 10-beat packet against LENGTH=9
    for (int i = 0; i < 10; i++) send(16'(16'h200 + i), i == 0, i == 9);
    rdchk("len10_status", 4'd2, LEN_EN ? 32'h000A_0014 : 32'h000A_0004);
    rdchk("len10_pktcount", 4'd4, 32'd4);
    wr(4'd0, 32'd3);

    // Clear collides with a valid eop beat
    for (int i = 0; i < 5; i++) send(16'(16'h50 + i), i == 0, 1'b0);
    rdchk("pre_clr_status", 4'd2, 32'h0005_0000);
    s_address = 4'd0; s_writedata = 32'd3; s_write = 1'b1;
    st_valid = 1'b1; st_data = 16'h0055; st_sop = 1'b0; st_eop = 1'b1;
    @(posedge clock); #1;
    s_write = 1'b0; st_valid = 1'b0;
    rdchk("clr_beat_status", 4'd2, 32'h0000_0001);
    rdchk("clr_beat_pktcount", 4'd4, 32'd4);
    send(16'h0077, 1'b0, 1'b0);
    rdchk("clr_fsm_idle", 4'd2, 32'h0000_0009);
    wr(4'd2, 32'h1C);
    rdchk("other_addr", 4'd7, 32'd0);

    // Asynchronous reset mid-packet with a read pending
    for (int i = 0; i < 40; i++) send(16'(i), i == 0, 1'b0);
    rdchk("pre_rst_pktcount", 4'd4, 32'd4);
    s_address = 4'd2; s_read = 1'b1;
    @(negedge clock);
    chk("pend_wait", 32'(s_waitrequest), 32'd1);
    clock_sreset = 1'b1;
    #1;
    chk("arst_wait", 32'(s_waitrequest), 32'd0);
    chk("arst_readdata", s_readdata, 32'd0);
    chk("arst_ready", 32'(st_ready), 32'd0);
    s_read = 1'b0;
    @(posedge clock); #1;
    clock_sreset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("post_rst_ready", 32'(st_ready), 32'd0);
    @(posedge clock); #1;
    rdchk("post_rst_status", 4'd2, 32'h0000_0001);
    rdchk("post_rst_pktcount", 4'd4, 32'd0);
    rdchk("post_rst_control", 4'd0, 32'd0);
    rdchk("post_rst_length", 4'd1, 32'd0);
    wr(4'd0, 32'd1);
    @(negedge clock);
    chk("reenable_ready", 32'(st_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
